// File: rtl/vcve2_vlsu_agu.sv
`default_nettype none
// ============================================================================
//  Module   : vcve2_vlsu_agu
//  Purpose  : Address generation and bus sequencing for unit-stride vector
//             loads/stores. Splits (base, vl, vsew) into word-aligned 32-bit
//             transfers on the cve2 LSU bus (req/gnt/rvalid), one transfer
//             outstanding at a time. Load words are passed to the VRF as they
//             return. Store words are pulled from the VRF one per transfer.
//  Ports    : clk_i/rst_ni       clock, asynchronous active-low reset
//             start_i ..vsew_i   operation request, sampled only in IDLE
//             busy_o/done_o/err_o status; err_o is only valid with done_o
//             vrf_*              VRF load-data and store-data handshakes
//             data_*             cve2 LSU data bus
//  Revision : 1.0 - initial release
// ============================================================================
module vcve2_vlsu_agu #(
    parameter int unsigned VLEN = 128,
    parameter int unsigned VlW  = $clog2(VLEN) + 1,
    parameter int unsigned IdxW = $clog2(VLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            is_store_i,
    input  logic [31:0]     base_addr_i,
    input  logic [VlW-1:0]  vl_i,
    input  logic [2:0]      vsew_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [31:0]     vrf_rdata_o,
    output logic            vrf_rdata_valid_o,
    output logic [IdxW-1:0] vrf_word_idx_o,
    input  logic [31:0]     vrf_wdata_i,
    input  logic            vrf_wdata_valid_i,
    output logic            vrf_wdata_ready_o,
    output logic            data_req_o,
    input  logic            data_gnt_i,
    input  logic            data_rvalid_i,
    input  logic            data_err_i,
    output logic [31:0]     data_addr_o,
    output logic            data_we_o,
    output logic [3:0]      data_be_o,
    output logic [31:0]     data_wdata_o,
    input  logic [31:0]     data_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WDATA = 3'd1,
        S_REQ   = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e          state_q;
    logic            is_store_q;
    logic            err_q;
    logic [31:0]     base_q;
    logic [31:0]     wdata_q;
    logic [IdxW-1:0] idx_q;
    logic [IdxW-1:0] last_idx_q;
    logic [1:0]      tail_q;

    // ------------------------------------------------------------------
    // Start decode: byte and word counts of the request.
    // Only vsew 0..2 is legal, so a 2-bit shift amount is sufficient.
    // ------------------------------------------------------------------
    logic [VlW+1:0]  w_nbytes;
    logic [VlW+1:0]  w_nbytes_p3;
    logic [VlW-1:0]  w_nwords;
    logic [VlW-1:0]  w_last_word;
    logic            w_bad_sew;
    logic            w_misaligned;

    assign w_nbytes     = {2'b00, vl_i} << vsew_i[1:0];
    assign w_nbytes_p3  = w_nbytes + (VlW+2)'(3);
    assign w_nwords     = w_nbytes_p3[VlW+1:2];
    assign w_last_word  = w_nwords - VlW'(1);
    assign w_bad_sew    = (vsew_i[2] == 1'b1) || (vsew_i[1:0] == 2'b11);
    assign w_misaligned = (base_addr_i[1:0] != 2'b00);

    // ------------------------------------------------------------------
    // Transfer attributes for the current word
    // ------------------------------------------------------------------
    logic            w_last;
    logic [3:0]      w_tail_be;
    logic [3:0]      w_be;
    logic [31:0]     w_addr;
    logic            w_busy;

    assign w_last = (idx_q == last_idx_q);

    always_comb begin
        w_tail_be = 4'b1111;
        case (tail_q)
            2'd1:    w_tail_be = 4'b0001;
            2'd2:    w_tail_be = 4'b0011;
            2'd3:    w_tail_be = 4'b0111;
            default: w_tail_be = 4'b1111;
        endcase
    end

    // A partial final word only enables the bytes actually covered by vl.
    assign w_be   = w_last ? w_tail_be : 4'b1111;
    assign w_addr = base_q + {{(30-IdxW){1'b0}}, idx_q, 2'b00};
    assign w_busy = (state_q != S_IDLE);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            err_q      <= 1'b0;
            base_q     <= '0;
            wdata_q    <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            tail_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        is_store_q <= is_store_i;
                        base_q     <= base_addr_i;
                        wdata_q    <= '0;
                        idx_q      <= '0;
                        last_idx_q <= IdxW'(w_last_word);
                        tail_q     <= w_nbytes[1:0];
                        err_q      <= 1'b0;
                        if (w_bad_sew || w_misaligned) begin
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else if (vl_i == '0) begin
                            state_q <= S_DONE;
                        end else if (is_store_i) begin
                            state_q <= S_WDATA;
                        end else begin
                            state_q <= S_REQ;
                        end
                    end
                end
                S_WDATA: begin
                    if (vrf_wdata_valid_i) begin
                        wdata_q <= vrf_wdata_i;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    // rvalid is deliberately ignored here: it cannot belong
                    // to a transfer that has not yet been granted.
                    if (data_gnt_i) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (data_rvalid_i) begin
                        if (data_err_i) begin
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else if (w_last) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q + IdxW'(1);
                            state_q <= is_store_q ? S_WDATA : S_REQ;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all decoded from registered state. Bus attributes are
    // forced to zero while idle so the interface is quiet between ops.
    // ------------------------------------------------------------------
    assign busy_o            = w_busy;
    assign done_o            = (state_q == S_DONE);
    assign err_o             = (state_q == S_DONE) && err_q;

    assign vrf_rdata_valid_o = (state_q == S_WAIT) && data_rvalid_i &&
                               !data_err_i && !is_store_q;
    assign vrf_rdata_o       = vrf_rdata_valid_o ? data_rdata_i : 32'h0;
    assign vrf_word_idx_o    = idx_q;
    assign vrf_wdata_ready_o = (state_q == S_WDATA);

    assign data_req_o        = (state_q == S_REQ);
    assign data_addr_o       = w_busy ? w_addr : 32'h0;
    assign data_we_o         = w_busy && is_store_q;
    assign data_be_o         = w_busy ? w_be : 4'b0000;
    assign data_wdata_o      = w_busy ? wdata_q : 32'h0;

endmodule
`default_nettype wire

// File: doc/vcve2_vlsu_agu.md
Name: vcve2_vlsu_agu

Overview:
Address-generation and bus-sequencing unit for unit-stride vector loads and stores (OPCODE_LOAD_V / OPCODE_STORE_V). It sits between the vector register file controller, which waits on it in VRF_WAITAGU / VRF_WAITBUS, and the core data bus, which uses the cve2 LSU protocol (req/gnt/rvalid).
- Converts (base, vl, vsew) into a sequence of word-aligned 32-bit transfers, with one transfer outstanding at a time.
- Returns load words to the VRF, or pulls store words from it.

Parameters:
VLEN, 128, vector register length in bits; must be a power of 2, at least 32.
VlW, $clog2(VLEN)+1, width of vl_i.
IdxW, $clog2(VLEN)+1, width of the word index; covers VLEN*8/32 words (LMUL=8).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  one-cycle request; sampled only in IDLE
is_store_i  in  1  1 = store, 0 = load; sampled with start_i
base_addr_i  in  32  base byte address
vl_i  in  VlW  element count
vsew_i  in  3  vsew_e encoding
busy_o  out  1  high in any state other than IDLE
done_o  out  1  one-cycle completion pulse
err_o  out  1  valid with done_o: misaligned base, illegal vsew, or bus error
vrf_rdata_o  out  32  load word to VRF
vrf_rdata_valid_o  out  1  one-cycle pulse per load word
vrf_word_idx_o  out  IdxW  index of the current word (load data or store request)
vrf_wdata_i  in  32  store word from VRF
vrf_wdata_valid_i  in  1  store word valid
vrf_wdata_ready_o  out  1  AGU accepts a store word
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant
data_rvalid_i  in  1  bus response valid
data_err_i  in  1  bus error; qualified by rvalid
data_addr_o  out  32  word-aligned address
data_we_o  out  1  write enable
data_be_o  out  4  byte enables
data_wdata_o  out  32  store data
data_rdata_i  in  32  load data

Behaviour:
- Reset: the state machine returns to IDLE asynchronously. All outputs are 0. Counters and latches are 0.
- A reset in the middle of an operation drops data_req_o immediately. No done_o is issued for the aborted operation.
- States and transitions:
  - IDLE: waits for start_i.
  - WDATA (stores only): vrf_wdata_ready_o=1. On vrf_wdata_valid_i, latch the word and go to REQ.
  - REQ: data_req_o=1. Hold addr, we, be and wdata stable until data_gnt_i, then go to WAIT.
  - WAIT: on data_rvalid_i, either go to DONE (error, or last word) or go to the next word (REQ for loads, WDATA for stores).
  - DONE: done_o=1 for one cycle, then IDLE.
- start_i in IDLE:
  - If vsew_i is not in {000, 001, 010}: latch err, go to DONE.
  - Else if base_addr_i[1:0] != 0: latch err, go to DONE.
  - Else if vl_i == 0: go to DONE with err=0.
  - Otherwise: nbytes = vl_i << vsew_i, nwords = ceil(nbytes/4), idx = 0. Go to REQ (load) or WDATA (store).
- start_i is ignored while busy_o=1.
- Transfer address and enables:
  - data_addr_o = base + (idx << 2).
  - data_be_o = 4'b1111, except on the final word when nbytes[1:0] != 0, where it is (1 << nbytes[1:0]) - 1.
  - data_we_o = is_store for the whole operation.
- Bus timing:
  - rvalid arrives no earlier than the cycle after gnt.
  - The AGU ignores rvalid while in REQ.
  - A gnt outside REQ is ignored.
- Load data: on rvalid in WAIT with data_err_i=0:
  - vrf_rdata_o = data_rdata_i and vrf_rdata_valid_o=1 in the same cycle (combinational pass-through).
  - vrf_word_idx_o = idx.
  - idx increments at the end of that cycle.
- Bus error:
  - On rvalid with data_err_i=1: no vrf_rdata_valid_o, latch err, go to DONE.
  - Remaining words are abandoned.
- Latency:
  - Load, start to first data_req_o: 1 cycle.
  - Final rvalid to done_o: 1 cycle.
  - Between words, data_req_o reasserts the cycle after rvalid.
- err_o is driven from the latched err bit during DONE and is 0 otherwise.

Test Plan:
- Load, vl=5, vsew=010, base 0x1000, gnt same cycle as req, rvalid 1 cycle later -> 5 requests to 0x1000..0x1010, be=1111, five vrf_rdata_valid_o pulses with idx 0..4, done_o=1, err_o=0.
- Load, vl=7, vsew=000, base 0x2000 -> 2 words, be 1111 then 0111; start to first req 1 cycle.
- Store, vl=3, vsew=001, base 0x3000, vrf_wdata_valid_i delayed 2 cycles per word -> vrf_wdata_ready_o held high while waiting, writes 0x3000 (be 1111) and 0x3004 (be 0011), data_wdata_o matches VRF words.
- gnt withheld for 3 cycles -> data_req_o, data_addr_o, data_be_o and data_wdata_o stable throughout; a new start_i issued meanwhile is ignored.
- data_err_i on word 2 of a vl=4 vsew=010 load -> no data pulse for idx 2, no request for word 3, done_o together with err_o=1.
- Illegal setups:
  - base 0x1002 -> done_o with err_o=1 the cycle after start, no data_req_o.
  - vsew=111 -> same as base 0x1002.
  - vl=0 -> done_o with err_o=0, no data_req_o.
  - rst_ni low while in REQ -> data_req_o drops immediately, no done_o.
